// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer, its datapath and the bench.
package shift_sequencer_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_CPL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sequencer_rep_counter.sv
// Repetition down-counter: load, decrement-enable and zero flag; never wraps below 0.
module rep_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for the 4-bit universal shifter datapath.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [0:3]       cmd_data,
    input  logic [0:1]       cmd_op,
    input  logic [0:1]       cmd_amt,
    input  logic [CNT_W-1:0] cmd_reps,
    output logic [0:3]       dp_in,
    output logic             dp_load,
    output logic             dp_rg,
    output logic [0:1]       dp_ch,
    output logic [0:1]       dp_sh,
    input  logic [0:3]       dp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [0:3]       res_data,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] reps_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_last;

    assign cnt_load     = (state == ST_LOAD);
    assign cnt_load_val = (reps_q == '0) ? '0 : reps_q - CNT_W'(1);
    assign cnt_dec      = (state == ST_RUN);
    assign cnt_last     = (cnt == CNT_W'(1)) || cnt_zero;

    rep_counter #(
        .CNT_W (CNT_W)
    ) u_rep_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // The register holds in DONE, so dp_out is already stable there.
    assign res_data = res_valid ? dp_out : '0;

    // dp_in, dp_ch and dp_sh double as the command latch for data/op/amt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            reps_q    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            dp_in     <= '0;
            dp_load   <= 1'b0;
            dp_rg     <= 1'b0;
            dp_ch     <= '0;
            dp_sh     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_LOAD;
                        reps_q    <= cmd_reps;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dp_in     <= cmd_data;
                        dp_load   <= 1'b1;
                        dp_rg     <= 1'b0;
                        dp_ch     <= (cmd_reps == '0) ? OP_PASS : cmd_op;
                        dp_sh     <= cmd_amt;
                    end
                end
                ST_LOAD: begin
                    dp_in <= '0;
                    if (reps_q <= CNT_W'(1)) begin
                        state     <= ST_DONE;
                        dp_load   <= 1'b0;
                        dp_rg     <= 1'b0;
                        res_valid <= 1'b1;
                    end else begin
                        state   <= ST_RUN;
                        dp_load <= 1'b1;
                        dp_rg   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_last) begin
                        state     <= ST_DONE;
                        dp_load   <= 1'b0;
                        dp_rg     <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        dp_ch     <= '0;
                        dp_sh     <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shifter datapath and result scoreboard.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [0:3] cmd_data;
    logic [0:1] cmd_op;
    logic [0:1] cmd_amt;
    logic [3:0] cmd_reps;
    logic [0:3] dp_in;
    logic       dp_load;
    logic       dp_rg;
    logic [0:1] dp_ch;
    logic [0:1] dp_sh;
    logic [0:3] dp_out;
    logic       res_valid;
    logic       res_ready;
    logic [0:3] res_data;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned acc_cyc = 0;
    int unsigned runs    = 0;
    logic [1:0]  ch_or;
    logic [3:0]  trace_q[$];
    logic [3:0]  exp_q[$];
    int unsigned lat_q[$];

    shift_sequencer #(
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_reps  (cmd_reps),
        .dp_in     (dp_in),
        .dp_load   (dp_load),
        .dp_rg     (dp_rg),
        .dp_ch     (dp_ch),
        .dp_sh     (dp_sh),
        .dp_out    (dp_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] apply(input logic [3:0] d, input logic [1:0] op, input logic [1:0] amt);
        case (op)
            OP_PASS: apply = d;
            OP_CPL:  apply = ~d;
            OP_SHR:  apply = d >> amt;
            default: apply = d << amt;
        endcase
    endfunction

    function automatic logic [3:0] expect_result(input logic [3:0] d, input logic [1:0] op,
                                                 input logic [1:0] amt, input logic [3:0] reps);
        logic [3:0] v = d;
        for (int i = 0; i < int'(reps); i++) v = apply(v, op, amt);
        return v;
    endfunction

    // Shifter datapath: register captures the operated value of the selected source.
    logic [0:3] dp_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dp_reg <= '0;
        else if (dp_load) dp_reg <= apply(dp_rg ? dp_reg : dp_in, dp_ch, dp_sh);
    end
    assign dp_out = dp_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] op, input logic [1:0] amt, input logic [3:0] reps);
        int unsigned w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_send", cmd_ready, 1);
        cmd_data  = d;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_reps  = reps;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        exp_q.push_back(expect_result(d, (reps == 0) ? OP_PASS : op, amt, reps));
        lat_q.push_back((reps == 0) ? 1 : int'(reps));
    endtask

    task automatic collect(input string tag, input int unsigned hold);
        int unsigned k = 0;
        logic [3:0]  first;
        logic [3:0]  e;
        int unsigned l;
        res_ready = 1'b0;
        runs      = 0;
        ch_or     = '0;
        trace_q.delete();
        do begin
            @(negedge clk);
            k++;
            ch_or = ch_or | dp_ch;
            if (dp_load && dp_rg) runs++;
            if (cyc > acc_cyc) trace_q.push_back(dp_out);
        end while (!res_valid && k < 40);
        chk({tag, "_valid"}, res_valid, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk({tag, "_latency"}, cyc - acc_cyc, l);
        chk({tag, "_data"}, res_data, e);
        first = res_data;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, res_data, first);
            chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 4'b1111;
        cmd_op    = OP_SHL;
        cmd_amt   = 2'd1;
        cmd_reps  = 4'd3;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_dp_load", dp_load, 0);
        chk("reset_dp_ctrl", {dp_in, dp_rg, dp_ch, dp_sh, res_data}, 0);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", busy, 0);

        // Left shift x3: register walks 0110, 1100, 1000.
        send(4'b1011, OP_SHL, 2'd1, 4'd3);
        collect("shl3", 0);
        chk("shl3_trace_len", trace_q.size(), 3);
        if (trace_q.size() == 3) begin
            chk("shl3_trace0", trace_q[0], 4'b0110);
            chk("shl3_trace1", trace_q[1], 4'b1100);
            chk("shl3_trace2", trace_q[2], 4'b1000);
        end
        chk("shl3_const", res_data === 4'b0000 && exp_q.size() == 0, 1);

        send(4'b1011, OP_SHR, 2'd1, 4'd1);
        collect("shr1", 0);
        chk("shr1_no_run", runs, 0);

        send(4'b1011, OP_CPL, 2'd0, 4'd2);
        collect("cpl2", 0);
        send(4'b1011, OP_CPL, 2'd0, 4'd1);
        collect("cpl1", 0);

        send(4'b1010, OP_SHL, 2'd0, 4'd3);
        collect("shl_amt0", 0);

        // Zero reps, with a second command waiting while the result is held.
        send(4'b1101, OP_SHL, 2'd2, 4'd0);
        cmd_data  = 4'b0011;
        cmd_op    = OP_CPL;
        cmd_amt   = 2'd0;
        cmd_reps  = 4'd1;
        cmd_valid = 1'b1;
        collect("zero_reps", 5);
        chk("zero_reps_ch", ch_or, 0);
        chk("idle_gap_busy", busy, 0);
        chk("idle_gap_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        exp_q.push_back(4'b1100);
        lat_q.push_back(1);
        collect("b2b", 0);

        // Reset in the middle of RUN.
        send(4'b0101, OP_SHL, 2'd1, 4'd15);
        repeat (4) @(negedge clk);
        chk("mid_run_busy", busy, 1);
        chk("mid_run_rg", dp_rg, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_cmd_ready", cmd_ready, 1);
        chk("async_reset_dp_load", dp_load, 0);
        @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (res_valid) seen = 1'b1;
            end
            chk("no_res_after_reset", seen, 0);
        end
        send(4'b1000, OP_SHR, 2'd3, 4'd1);
        collect("after_reset", 0);

        send(4'b1111, OP_SHL, 2'd1, 4'd15);
        collect("max_reps", 0);
        chk("max_reps_runs", runs, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
